// File: rtl/echo_gen_pkg.sv
// Shared defaults, timestamp type and wrap-safe compare for the echo pulse generator.
package echo_gen_pkg;

    localparam int unsigned TS_W_DEF   = 8;
    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned STOP_W_DEF = 2;

    typedef logic [TS_W_DEF-1:0] ts_t;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1 (bits 15,13,12,10)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // True once `now` has reached or passed `due`, valid for distances below half the wrap
    function automatic logic ts_reached(input ts_t now, input ts_t due);
        ts_t diff;
        diff = now - due;
        return ~diff[TS_W_DEF-1];
    endfunction

endpackage

// File: rtl/echo_pulse_generator_if.sv
// Start/stop link bundle between the phase-counter side (master) and the echo generator (slave).
// With ECHO_JITTER_EN defined the bundle also carries jitter_last.
interface echo_pulse_generator_if
    import echo_gen_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
);
    localparam int unsigned PW = $clog2(DEPTH) + 1;

    logic          enable;
    logic          start;
    logic [6:0]    delay_cfg;
    logic          stop;
    logic          busy;
    logic [PW-1:0] pending;
    logic [7:0]    drop_cnt;

`ifdef ECHO_JITTER_EN
    logic [1:0]    jitter_last;

    modport master (output enable, start, delay_cfg,
                    input  stop, busy, pending, drop_cnt, jitter_last);
    modport slave  (input  enable, start, delay_cfg,
                    output stop, busy, pending, drop_cnt, jitter_last);
`else
    modport master (output enable, start, delay_cfg,
                    input  stop, busy, pending, drop_cnt);
    modport slave  (input  enable, start, delay_cfg,
                    output stop, busy, pending, drop_cnt);
`endif

endinterface

// File: rtl/echo_fifo.sv
// Synchronous FIFO of due timestamps; a push into a full FIFO is accepted when a pop happens the same cycle.
module echo_fifo
    import echo_gen_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter type         data_t = ts_t
) (
    input  logic                 clk_fast,
    input  logic                 rstn,
    input  logic                 push,
    input  logic                 pop,
    input  data_t                din,
    output data_t                dout_c,
    output logic                 full_c,
    output logic                 empty_c,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    data_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push_c;
    logic          do_pop_c;

    assign full_c    = (count == CW'(DEPTH));
    assign empty_c   = (count == '0);
    assign do_pop_c  = pop & ~empty_c;
    assign do_push_c = push & (~full_c | do_pop_c);
    assign dout_c    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count
    always_ff @(posedge clk_fast) begin
        if (do_push_c) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/echo_pulse_generator.sv
// Returns a `stop` echo a programmed number of clk_fast ticks after each `start` rising edge.
// Optional build macro ECHO_JITTER_EN adds 0..3 ticks of LFSR dither per echo and the jitter_last output.
module echo_pulse_generator
    import echo_gen_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned TS_W   = TS_W_DEF,
    parameter int unsigned STOP_W = STOP_W_DEF
) (
    input  logic                   clk_fast,
    input  logic                   rstn,
    echo_pulse_generator_if.slave  bus
);
    localparam int unsigned PW    = $clog2(DEPTH) + 1;
    localparam int unsigned CNT_W = $clog2(STOP_W + 1);

    typedef logic [TS_W-1:0] stamp_t;

    stamp_t           now;
    stamp_t           head_due_c;
    stamp_t           delay_c;
    stamp_t           due_c;
    logic             start_q;
    logic             req_c;
    logic             fire_c;
    logic             full_c;
    logic             empty_c;
    logic             push_ok_c;
    logic             drop_c;
    logic [PW-1:0]    count;
    logic [PW-1:0]    count_nxt_c;
    logic [CNT_W-1:0] pulse_cnt;
    logic [CNT_W-1:0] pulse_cnt_nxt_c;
    logic             stop_r;
    logic             busy_r;
    logic [7:0]       drop_r;

    assign req_c     = bus.start & ~start_q & bus.enable;
    assign push_ok_c = req_c & (~full_c | fire_c);
    assign drop_c    = req_c & full_c & ~fire_c;

    // A zero delay is promoted to one so an echo never lands on its own start cycle
    assign delay_c = (bus.delay_cfg == 7'd0) ? stamp_t'(1) : stamp_t'(bus.delay_cfg);

`ifdef ECHO_JITTER_EN
    logic [15:0] lfsr;
    logic [1:0]  jitter_r;

    assign due_c           = now + delay_c + stamp_t'(lfsr[1:0]);
    assign bus.jitter_last = jitter_r;

    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            lfsr     <= LFSR_SEED;
            jitter_r <= 2'd0;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            if (push_ok_c) begin
                jitter_r <= lfsr[1:0];
            end
        end
    end
`else
    assign due_c = now + delay_c;
`endif

    echo_fifo #(
        .DEPTH  (DEPTH),
        .data_t (stamp_t)
    ) u_fifo (
        .clk_fast (clk_fast),
        .rstn     (rstn),
        .push     (req_c),
        .pop      (fire_c),
        .din      (due_c),
        .dout_c   (head_due_c),
        .full_c   (full_c),
        .empty_c  (empty_c),
        .count    (count)
    );

    // Only the head is examined; a later entry whose due already passed fires as soon as it surfaces
    generate
        if (TS_W == TS_W_DEF) begin : g_pkg_cmp
            assign fire_c = ~empty_c & ts_reached(ts_t'(now), ts_t'(head_due_c));
        end else begin : g_gen_cmp
            stamp_t diff_c;
            assign diff_c = now - head_due_c;
            assign fire_c = ~empty_c & ~diff_c[TS_W-1];
        end
    endgenerate

    always_comb begin
        count_nxt_c = count;
        case ({push_ok_c, fire_c})
            2'b10:   count_nxt_c = count + PW'(1);
            2'b01:   count_nxt_c = count - PW'(1);
            default: count_nxt_c = count;
        endcase
    end

    // A fire during an active pulse reloads the counter, merging overlapping echoes
    always_comb begin
        pulse_cnt_nxt_c = pulse_cnt;
        if (fire_c) begin
            pulse_cnt_nxt_c = CNT_W'(STOP_W);
        end else if (pulse_cnt != '0) begin
            pulse_cnt_nxt_c = pulse_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_fast or negedge rstn) begin
        if (!rstn) begin
            now       <= '0;
            start_q   <= 1'b0;
            pulse_cnt <= '0;
            stop_r    <= 1'b0;
            busy_r    <= 1'b0;
            drop_r    <= 8'd0;
        end else begin
            now       <= now + stamp_t'(1);
            start_q   <= bus.start;
            pulse_cnt <= pulse_cnt_nxt_c;
            stop_r    <= (pulse_cnt_nxt_c != '0);
            busy_r    <= (count_nxt_c != '0) | (pulse_cnt_nxt_c != '0);
            if (drop_c && (drop_r != 8'hFF)) begin
                drop_r <= drop_r + 8'd1;
            end
        end
    end

    assign bus.stop     = stop_r;
    assign bus.busy     = busy_r;
    assign bus.pending  = count;
    assign bus.drop_cnt = drop_r;

endmodule

// File: tb/tb_echo_pulse_generator.sv
// Self-checking bench for echo_pulse_generator: vector table plus multi-cycle sequences, stop edges scored against a queue.
module tb_echo_pulse_generator;

    localparam int unsigned DEPTH  = 4;
    localparam int          STOP_W = 2;

    typedef struct {
        int rise;
        int width;
    } exp_t;

    typedef struct {
        int d;
        bit en;
        int hold;
        int lat;
        int pend;
        int bsy;
    } vec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   now_m    = 0;
    exp_t sb[$];
    logic stop_prev = 1'b0;
    int   rise_at   = 0;
    int   exp_w     = 0;
    bit   in_pulse  = 1'b0;
    vec_t vecs[7];

    echo_pulse_generator_if #(.DEPTH(DEPTH)) bus ();

    echo_pulse_generator #(
        .DEPTH  (DEPTH),
        .TS_W   (8),
        .STOP_W (STOP_W)
    ) dut (
        .clk_fast (clk),
        .rstn     (rstn),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference timestamp, used only to aim the wrap test at now=250
    always @(posedge clk or negedge rstn) begin
        if (!rstn) now_m <= 0;
        else       now_m <= (now_m + 1) % 256;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: observed %0d, required no such event (cycle %0d)", name, act, cyc);
    endtask

    // Scoreboard: each stop rising edge pops one expectation and checks rise cycle and width
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.stop === 1'b1 && stop_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                flag("unexpected_stop", cyc);
            end else begin
                e = sb.pop_front();
                chk("stop_rise_cycle", cyc, e.rise);
                chk("busy_with_stop", int'(bus.busy), 1);
                rise_at  = cyc;
                exp_w    = e.width;
                in_pulse = 1'b1;
            end
        end
        if (bus.stop !== 1'b1 && stop_prev === 1'b1 && in_pulse) begin
            chk("stop_width", cyc - rise_at, exp_w);
            in_pulse = 1'b0;
        end
        stop_prev = bus.stop;
    end

    task automatic start_pulse(input int d, input bit en, input int hold, input int lat, output int k);
        @(posedge clk);
        #1;
        bus.delay_cfg = 7'(d);
        bus.enable    = en;
        bus.start     = 1'b1;
        k             = cyc;
        if (lat > 0) sb.push_back(exp_t'{rise: cyc + lat, width: STOP_W});
        repeat (hold) @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int i;
        i = 0;
        while ((sb.size() != 0 || bus.stop === 1'b1 || in_pulse) && i < limit) begin
            @(negedge clk);
            i++;
        end
        if (i >= limit) flag(name, sb.size());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  k2;
        bit  found;

        vecs[0] = '{d: 10,  en: 1'b1, hold: 1, lat: 11,  pend: 1, bsy: 1};
        vecs[1] = '{d: 0,   en: 1'b1, hold: 1, lat: 2,   pend: 1, bsy: 1};
        vecs[2] = '{d: 1,   en: 1'b1, hold: 2, lat: 2,   pend: 0, bsy: 1};
        vecs[3] = '{d: 127, en: 1'b1, hold: 1, lat: 128, pend: 1, bsy: 1};
        vecs[4] = '{d: 5,   en: 1'b0, hold: 1, lat: 0,   pend: 0, bsy: 0};
        vecs[5] = '{d: 37,  en: 1'b1, hold: 3, lat: 38,  pend: 1, bsy: 1};
        vecs[6] = '{d: 2,   en: 1'b1, hold: 4, lat: 3,   pend: 0, bsy: 1};

        bus.start     = 1'b0;
        bus.enable    = 1'b0;
        bus.delay_cfg = 7'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stop",     int'(bus.stop),     0);
        chk("reset_busy",     int'(bus.busy),     0);
        chk("reset_pending",  int'(bus.pending),  0);
        chk("reset_drop_cnt", int'(bus.drop_cnt), 0);
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            start_pulse(vecs[i].d, vecs[i].en, vecs[i].hold, vecs[i].lat, k);
            chk($sformatf("vec%0d_pending", i), int'(bus.pending), vecs[i].pend);
            chk($sformatf("vec%0d_busy", i),    int'(bus.busy),    vecs[i].bsy);
            wait_drain($sformatf("vec%0d_drain_timeout", i), 300);
            repeat (20) @(negedge clk);
            chk($sformatf("vec%0d_idle_pending", i), int'(bus.pending), 0);
            chk($sformatf("vec%0d_idle_busy", i),    int'(bus.busy),    0);
        end

        // enable dropped with an echo in flight: it still fires, new starts ignored
        start_pulse(15, 1'b1, 1, 16, k);
        bus.enable = 1'b0;
        start_pulse(3, 1'b0, 1, 0, k2);
        chk("en_off_pending", int'(bus.pending), 1);
        chk("en_off_busy",    int'(bus.busy),    1);
        wait_drain("en_off_drain_timeout", 100);
        repeat (3) @(negedge clk);
        chk("en_off_idle_busy", int'(bus.busy), 0);

        // four starts 3 ticks apart fill the queue; a fifth is dropped
        for (int j = 0; j < 4; j++) begin
            start_pulse(20, 1'b1, 1, 21, k);
            @(posedge clk);
        end
        start_pulse(20, 1'b1, 1, 0, k);
        chk("full_pending",  int'(bus.pending),  4);
        chk("full_drop_cnt", int'(bus.drop_cnt), 1);
        wait_drain("full_drain_timeout", 200);
        repeat (3) @(negedge clk);
        chk("full_after_drop_cnt", int'(bus.drop_cnt), 1);
        chk("full_after_pending",  int'(bus.pending),  0);

        // echoes one tick apart merge into a single 3-tick pulse
        start_pulse(5, 1'b1, 1, 0, k);
        sb.push_back(exp_t'{rise: k + 6, width: 3});
        start_pulse(4, 1'b1, 1, 0, k2);
        wait_drain("merge_drain_timeout", 100);
        repeat (5) @(negedge clk);

        // shorter delay queued behind a long head fires the tick after the head
        start_pulse(30, 1'b1, 1, 0, k);
        sb.push_back(exp_t'{rise: k + 31, width: 3});
        start_pulse(2, 1'b1, 1, 0, k2);
        chk("order_pending", int'(bus.pending), 2);
        wait_drain("order_drain_timeout", 100);
        repeat (5) @(negedge clk);
        chk("order_idle_pending", int'(bus.pending), 0);

        // level-held start gives one echo only
        start_pulse(10, 1'b1, 50, 11, k);
        wait_drain("hold_drain_timeout", 100);
        repeat (10) @(negedge clk);
        chk("hold_idle_pending", int'(bus.pending), 0);

        // request at now=250 with delay 100 crosses the timestamp wrap
        repeat (600) @(posedge clk);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            #1;
            if (now_m == 249) found = 1'b1;
        end
        if (!found) flag("wrap_align_timeout", now_m);
        start_pulse(100, 1'b1, 1, 101, k);
        wait_drain("wrap_drain_timeout", 300);
        repeat (3) @(negedge clk);

        // reset with echoes pending discards them all
        start_pulse(100, 1'b1, 1, 0, k);
        start_pulse(100, 1'b1, 1, 0, k);
        start_pulse(100, 1'b1, 1, 0, k);
        chk("prereset_pending", int'(bus.pending), 3);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("midreset_stop",     int'(bus.stop),     0);
        chk("midreset_busy",     int'(bus.busy),     0);
        chk("midreset_pending",  int'(bus.pending),  0);
        chk("midreset_drop_cnt", int'(bus.drop_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (200) @(negedge clk);
        chk("postreset_busy",    int'(bus.busy),    0);
        chk("postreset_pending", int'(bus.pending), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
